// File: rtl/ro_puf_challenger.sv
// Challenge sequencer for the ring-oscillator PUF core: steps through a latched
// challenge list, gates each counting window and packs one response bit per challenge.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; PUF counters held in reset
// LOAD   | drive sel1/sel2 for challenge idx
// CLR    | two cycles of counter reset with selects already stable
// RUN    | WIN cycles of counting (puf_enable high)
// HOLD   | SETTLE cycles for the asynchronous ring counters to settle
// CMP    | compare count_1/count_2 into response[idx]
// FIN    | one-cycle done pulse, then back to IDLE
module ro_puf_challenger #(
    parameter int N_CHAL = 8,
    parameter int WIN    = 200,
    parameter int CW     = 8,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [6*N_CHAL-1:0]   chal,
    output logic [2:0]            sel1,
    output logic [2:0]            sel2,
    output logic                  puf_enable,
    output logic                  puf_reset,
    input  logic [CW-1:0]         count_1,
    input  logic [CW-1:0]         count_2,
    output logic [N_CHAL-1:0]     response,
    output logic                  tie,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (N_CHAL > 1) ? $clog2(N_CHAL) : 1;
    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_HOLD,
        S_CMP,
        S_FIN
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [TW-1:0]       tmr, tmr_nxt;
    logic                tmr_tc;
    logic [6*N_CHAL-1:0] chal_q;
    logic [6*N_CHAL-1:0] chal_src;
    logic                accept;

    assign tmr_tc   = (tmr == '0);
    assign accept   = (state == S_IDLE) && start;
    // LOAD of challenge 0 happens on the same edge that latches chal
    assign chal_src = (state == S_IDLE) ? chal : chal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            idx   <= '0;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_nxt   = tmr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_nxt = S_CLR;
                tmr_nxt   = TW'(1);
            end
            S_CLR: begin
                if (tmr_tc) begin
                    state_nxt = S_RUN;
                    tmr_nxt   = TW'(WIN - 1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_RUN: begin
                if (tmr_tc) begin
                    state_nxt = S_HOLD;
                    tmr_nxt   = TW'(SETTLE - 1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_HOLD: begin
                if (tmr_tc) begin
                    state_nxt = S_CMP;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_CMP: begin
                if (idx == IW'(N_CHAL - 1)) begin
                    state_nxt = S_FIN;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    state_nxt = S_LOAD;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel1       <= '0;
            sel2       <= '0;
            puf_enable <= 1'b0;
            puf_reset  <= 1'b1;
            response   <= '0;
            tie        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chal_q     <= '0;
        end else begin
            puf_enable <= (state_nxt == S_RUN);
            puf_reset  <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD) ||
                          (state_nxt == S_CLR)  || (state_nxt == S_FIN);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_FIN);
            done       <= (state_nxt == S_FIN);
            if (state_nxt == S_LOAD) begin
                sel1 <= chal_src[6*int'(idx_nxt) +: 3];
                sel2 <= chal_src[6*int'(idx_nxt) + 3 +: 3];
            end
            if (accept) begin
                chal_q   <= chal;
                response <= '0;
                tie      <= 1'b0;
            end
            if (state == S_CMP) begin
                response[idx] <= (count_1 > count_2);
                if (count_1 == count_2) begin
                    tie <= 1'b1;
                end
            end
        end
    end

endmodule
